// File: rtl/exu_pkg.sv
// Shared encodings for the execute-stage ALU: alu_ctrl codes, ALUOp classes,
// ALU funct3 values and branch funct3 values.
package exu_pkg;

    // Decoded ALU operation (alu_ctrl)
    localparam logic [3:0] ALU_AND  = 4'b0000;
    localparam logic [3:0] ALU_OR   = 4'b0001;
    localparam logic [3:0] ALU_ADD  = 4'b0010;
    localparam logic [3:0] ALU_XOR  = 4'b0011;
    localparam logic [3:0] ALU_SLL  = 4'b0100;
    localparam logic [3:0] ALU_SRL  = 4'b0101;
    localparam logic [3:0] ALU_SUB  = 4'b0110;
    localparam logic [3:0] ALU_SLT  = 4'b0111;
    localparam logic [3:0] ALU_SLTU = 4'b1000;
    localparam logic [3:0] ALU_SRA  = 4'b1101;

    // ALUOp classes from the main decoder
    localparam logic [1:0] AOP_MEM    = 2'b00;
    localparam logic [1:0] AOP_BRANCH = 2'b01;
    localparam logic [1:0] AOP_RTYPE  = 2'b10;
    localparam logic [1:0] AOP_ITYPE  = 2'b11;

    // ALU funct3 values
    localparam logic [2:0] F3_ADD  = 3'b000;
    localparam logic [2:0] F3_SLL  = 3'b001;
    localparam logic [2:0] F3_SLT  = 3'b010;
    localparam logic [2:0] F3_SLTU = 3'b011;
    localparam logic [2:0] F3_XOR  = 3'b100;
    localparam logic [2:0] F3_SR   = 3'b101;
    localparam logic [2:0] F3_OR   = 3'b110;
    localparam logic [2:0] F3_AND  = 3'b111;

    // Branch funct3 values
    localparam logic [2:0] BR_BEQ  = 3'b000;
    localparam logic [2:0] BR_BNE  = 3'b001;
    localparam logic [2:0] BR_BLT  = 3'b100;
    localparam logic [2:0] BR_BGE  = 3'b101;
    localparam logic [2:0] BR_BLTU = 3'b110;
    localparam logic [2:0] BR_BGEU = 3'b111;

endpackage

// File: rtl/exu_alu_decode.sv
// ALU control decoder: ALUOp / funct3 / funct7[5] -> 4-bit alu_ctrl.
// Purely combinational.
module exu_alu_decode
    import exu_pkg::*;
(
    input  logic [1:0] alu_op,
    input  logic [2:0] funct3,
    input  logic       funct7_b5,
    output logic [3:0] alu_ctrl
);

    // Map instruction class and function fields onto an ALU operation
    always_comb begin
        alu_ctrl = ALU_ADD;
        unique case (alu_op)
            AOP_MEM:    alu_ctrl = ALU_ADD;
            AOP_BRANCH: alu_ctrl = ALU_SUB;
            default: begin
                // R-type and I-type share the funct3 table; only R-type may
                // turn ADD into SUB, since I-type bit 30 is immediate data there.
                unique case (funct3)
                    F3_ADD:  alu_ctrl = (alu_op == AOP_RTYPE && funct7_b5) ? ALU_SUB : ALU_ADD;
                    F3_SLL:  alu_ctrl = ALU_SLL;
                    F3_SLT:  alu_ctrl = ALU_SLT;
                    F3_SLTU: alu_ctrl = ALU_SLTU;
                    F3_XOR:  alu_ctrl = ALU_XOR;
                    F3_SR:   alu_ctrl = funct7_b5 ? ALU_SRA : ALU_SRL;
                    F3_OR:   alu_ctrl = ALU_OR;
                    F3_AND:  alu_ctrl = ALU_AND;
                    default: alu_ctrl = ALU_ADD;
                endcase
            end
        endcase
    end

endmodule

// File: rtl/exec_alu_unit.sv
// Execute-stage arithmetic block: ALU control decode, N-bit ALU with a
// registered result/zero flag, and a combinational branch resolver feeding
// the PC-select mux. Optional macro EXU_BRANCH_EXT_EN enables full
// BEQ/BNE/BLT/BGE/BLTU/BGEU resolution; otherwise branches test equality only.
module exec_alu_unit
    import exu_pkg::*;
#(
    parameter int N = 32
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         in_valid,
    input  logic [1:0]   alu_op,
    input  logic [2:0]   funct3,
    input  logic         funct7_b5,
    input  logic [N-1:0] op_a,
    input  logic [N-1:0] op_b,
    input  logic         branch,
    input  logic [N-1:0] br_a,
    input  logic [N-1:0] br_b,
    input  logic [2:0]   br_funct3,
    output logic [3:0]   alu_ctrl,
    output logic [N-1:0] result,
    output logic         zero,
    output logic         out_valid,
    output logic         branch_taken
);

    localparam int SHW = $clog2(N);

    logic [N-1:0]   alu_res;
    logic [SHW-1:0] shamt;
    logic [N-1:0]   result_d, result_q;
    logic           zero_d, zero_q;
    logic           out_valid_d, out_valid_q;

    exu_alu_decode u_dec (
        .alu_op    (alu_op),
        .funct3    (funct3),
        .funct7_b5 (funct7_b5),
        .alu_ctrl  (alu_ctrl)
    );

    assign shamt = op_b[SHW-1:0];

    // ALU datapath; unlisted control codes yield zero
    always_comb begin
        alu_res = '0;
        unique case (alu_ctrl)
            ALU_AND:  alu_res = op_a & op_b;
            ALU_OR:   alu_res = op_a | op_b;
            ALU_XOR:  alu_res = op_a ^ op_b;
            ALU_ADD:  alu_res = op_a + op_b;
            ALU_SUB:  alu_res = op_a - op_b;
            ALU_SLL:  alu_res = op_a << shamt;
            ALU_SRL:  alu_res = op_a >> shamt;
            ALU_SRA:  alu_res = N'($signed(op_a) >>> shamt);
            ALU_SLT:  alu_res = {{(N-1){1'b0}}, ($signed(op_a) < $signed(op_b))};
            ALU_SLTU: alu_res = {{(N-1){1'b0}}, (op_a < op_b)};
            default:  alu_res = '0;
        endcase
    end

    // Next-state for the EX/MEM-side registers: capture on valid, else hold
    always_comb begin
        result_d    = result_q;
        zero_d      = zero_q;
        out_valid_d = in_valid;
        if (in_valid) begin
            result_d = alu_res;
            zero_d   = (alu_res == '0);
        end
    end

    // Result/zero/valid registers; reset presents a cleared, zero-flagged result
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            result_q    <= '0;
            zero_q      <= 1'b1;
            out_valid_q <= 1'b0;
        end else begin
            result_q    <= result_d;
            zero_q      <= zero_d;
            out_valid_q <= out_valid_d;
        end
    end

    assign result    = result_q;
    assign zero      = zero_q;
    assign out_valid = out_valid_q;

`ifdef EXU_BRANCH_EXT_EN
    // Full branch condition evaluation, same-cycle for the PC mux
    always_comb begin
        branch_taken = 1'b0;
        if (branch) begin
            unique case (br_funct3)
                BR_BEQ:  branch_taken = (br_a == br_b);
                BR_BNE:  branch_taken = (br_a != br_b);
                BR_BLT:  branch_taken = ($signed(br_a) <  $signed(br_b));
                BR_BGE:  branch_taken = ($signed(br_a) >= $signed(br_b));
                BR_BLTU: branch_taken = (br_a <  br_b);
                BR_BGEU: branch_taken = (br_a >= br_b);
                default: branch_taken = 1'b0;
            endcase
        end
    end
`else
    logic unused_br_funct3;
    assign unused_br_funct3 = ^br_funct3;

    // Equality-only branch resolution, same-cycle for the PC mux
    always_comb begin
        branch_taken = branch & (br_a == br_b);
    end
`endif

endmodule

// File: tb/tb_exec_alu_unit.sv
// Directed self-checking bench for exec_alu_unit (N=32).
module tb_exec_alu_unit;

    localparam int N = 32;

    logic         clk;
    logic         rst_n;
    logic         in_valid;
    logic [1:0]   alu_op;
    logic [2:0]   funct3;
    logic         funct7_b5;
    logic [N-1:0] op_a;
    logic [N-1:0] op_b;
    logic         branch;
    logic [N-1:0] br_a;
    logic [N-1:0] br_b;
    logic [2:0]   br_funct3;
    logic [3:0]   alu_ctrl;
    logic [N-1:0] result;
    logic         zero;
    logic         out_valid;
    logic         branch_taken;

    int n_checks;
    int n_fail;

    exec_alu_unit #(.N(N)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .in_valid     (in_valid),
        .alu_op       (alu_op),
        .funct3       (funct3),
        .funct7_b5    (funct7_b5),
        .op_a         (op_a),
        .op_b         (op_b),
        .branch       (branch),
        .br_a         (br_a),
        .br_b         (br_b),
        .br_funct3    (br_funct3),
        .alu_ctrl     (alu_ctrl),
        .result       (result),
        .zero         (zero),
        .out_valid    (out_valid),
        .branch_taken (branch_taken)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Apply ALU inputs at the falling edge
    task automatic drive(input logic v, input logic [1:0] op, input logic [2:0] f3,
                         input logic f7, input logic [N-1:0] a, input logic [N-1:0] b);
        @(negedge clk);
        in_valid  = v;
        alu_op    = op;
        funct3    = f3;
        funct7_b5 = f7;
        op_a      = a;
        op_b      = b;
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        n_checks++;
        if (result !== 32'h0 || zero !== 1'b1 || out_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_initial: result=%h zero=%b out_valid=%b, expected 0/1/0", result, zero, out_valid);
        end
        @(negedge clk);
        rst_n = 1'b1;
        drive(1'b1, 2'b10, 3'b000, 1'b0, 32'd5, 32'd7);
        step();
        // assert reset mid-operation with live inputs
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        n_checks++;
        if (result !== 32'h0 || zero !== 1'b1 || out_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_async: result=%h zero=%b out_valid=%b, expected 0/1/0", result, zero, out_valid);
        end
        step();
        n_checks++;
        if (result !== 32'h0 || zero !== 1'b1 || out_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_held: result=%h zero=%b out_valid=%b, expected 0/1/0", result, zero, out_valid);
        end
        @(negedge clk);
        rst_n = 1'b1;
        step();
        n_checks++;
        if (result !== 32'd12 || zero !== 1'b0 || out_valid !== 1'b1) begin
            n_fail++;
            $display("FAIL reset_release: result=%h zero=%b out_valid=%b, expected 0000000c/0/1", result, zero, out_valid);
        end
    endtask

    task automatic test_add_sub();
        drive(1'b1, 2'b10, 3'b000, 1'b0, 32'd5, 32'd7);
        #1;
        n_checks++;
        if (alu_ctrl !== 4'b0010) begin
            n_fail++;
            $display("FAIL add_ctrl: alu_ctrl=%b expected 0010", alu_ctrl);
        end
        step();
        n_checks++;
        if (result !== 32'd12 || zero !== 1'b0 || out_valid !== 1'b1) begin
            n_fail++;
            $display("FAIL add_result: result=%h zero=%b valid=%b expected 0000000c/0/1", result, zero, out_valid);
        end
        drive(1'b1, 2'b10, 3'b000, 1'b1, 32'd7, 32'd7);
        #1;
        n_checks++;
        if (alu_ctrl !== 4'b0110) begin
            n_fail++;
            $display("FAIL sub_ctrl: alu_ctrl=%b expected 0110", alu_ctrl);
        end
        step();
        n_checks++;
        if (result !== 32'd0 || zero !== 1'b1) begin
            n_fail++;
            $display("FAIL sub_result: result=%h zero=%b expected 00000000/1", result, zero);
        end
        // SUB wraps: 3 - 5
        drive(1'b1, 2'b01, 3'b000, 1'b0, 32'd3, 32'd5);
        step();
        n_checks++;
        if (result !== 32'hFFFF_FFFE || zero !== 1'b0) begin
            n_fail++;
            $display("FAIL branch_sub_wrap: result=%h zero=%b expected fffffffe/0", result, zero);
        end
    endtask

    task automatic test_logic();
        drive(1'b1, 2'b10, 3'b111, 1'b0, 32'hF0F0_00FF, 32'h0FF0_0F0F);
        step();
        n_checks++;
        if (result !== 32'h00F0_000F) begin
            n_fail++;
            $display("FAIL and: result=%h expected 00f0000f", result);
        end
        drive(1'b1, 2'b10, 3'b110, 1'b0, 32'hF0F0_00FF, 32'h0FF0_0F0F);
        step();
        n_checks++;
        if (result !== 32'hFFF0_0FFF) begin
            n_fail++;
            $display("FAIL or: result=%h expected fff00fff", result);
        end
        drive(1'b1, 2'b10, 3'b100, 1'b0, 32'hF0F0_00FF, 32'h0FF0_0F0F);
        step();
        n_checks++;
        if (result !== 32'hFF00_0FF0) begin
            n_fail++;
            $display("FAIL xor: result=%h expected ff000ff0", result);
        end
    endtask

    task automatic test_shift();
        drive(1'b1, 2'b10, 3'b101, 1'b0, 32'h8000_0000, 32'd4);
        #1;
        n_checks++;
        if (alu_ctrl !== 4'b0101) begin
            n_fail++;
            $display("FAIL srl_ctrl: alu_ctrl=%b expected 0101", alu_ctrl);
        end
        step();
        n_checks++;
        if (result !== 32'h0800_0000) begin
            n_fail++;
            $display("FAIL srl: result=%h expected 08000000", result);
        end
        drive(1'b1, 2'b10, 3'b101, 1'b1, 32'h8000_0000, 32'd4);
        #1;
        n_checks++;
        if (alu_ctrl !== 4'b1101) begin
            n_fail++;
            $display("FAIL sra_ctrl: alu_ctrl=%b expected 1101", alu_ctrl);
        end
        step();
        n_checks++;
        if (result !== 32'hF800_0000) begin
            n_fail++;
            $display("FAIL sra: result=%h expected f8000000", result);
        end
        // I-type SRAI honours funct7_b5
        drive(1'b1, 2'b11, 3'b101, 1'b1, 32'h8000_0000, 32'd4);
        #1;
        n_checks++;
        if (alu_ctrl !== 4'b1101) begin
            n_fail++;
            $display("FAIL srai_ctrl: alu_ctrl=%b expected 1101", alu_ctrl);
        end
        // shift amount uses low 5 bits only: 33 -> 1
        drive(1'b1, 2'b10, 3'b001, 1'b0, 32'h8000_0000, 32'd33);
        step();
        n_checks++;
        if (result !== 32'h0 || zero !== 1'b1) begin
            n_fail++;
            $display("FAIL sll_mask: result=%h zero=%b expected 00000000/1", result, zero);
        end
        drive(1'b1, 2'b10, 3'b001, 1'b0, 32'h0000_0003, 32'd33);
        step();
        n_checks++;
        if (result !== 32'h0000_0006) begin
            n_fail++;
            $display("FAIL sll_mask2: result=%h expected 00000006", result);
        end
    endtask

    task automatic test_compare();
        drive(1'b1, 2'b10, 3'b010, 1'b0, 32'hFFFF_FFFF, 32'd1);
        step();
        n_checks++;
        if (result !== 32'd1 || zero !== 1'b0) begin
            n_fail++;
            $display("FAIL slt: result=%h zero=%b expected 00000001/0", result, zero);
        end
        drive(1'b1, 2'b10, 3'b011, 1'b0, 32'hFFFF_FFFF, 32'd1);
        step();
        n_checks++;
        if (result !== 32'd0 || zero !== 1'b1) begin
            n_fail++;
            $display("FAIL sltu: result=%h zero=%b expected 00000000/1", result, zero);
        end
        drive(1'b1, 2'b11, 3'b000, 1'b1, 32'hFFFF_FFFF, 32'd1);
        #1;
        n_checks++;
        if (alu_ctrl !== 4'b0010) begin
            n_fail++;
            $display("FAIL itype_add_ctrl: alu_ctrl=%b expected 0010", alu_ctrl);
        end
        step();
        n_checks++;
        if (result !== 32'd0 || zero !== 1'b1) begin
            n_fail++;
            $display("FAIL itype_add: result=%h zero=%b expected 00000000/1", result, zero);
        end
    endtask

    task automatic test_hold();
        drive(1'b1, 2'b00, 3'b000, 1'b0, 32'd5, 32'd7);
        step();
        drive(1'b0, 2'b10, 3'b000, 1'b1, 32'd9, 32'd9);
        #1;
        n_checks++;
        if (alu_ctrl !== 4'b0110) begin
            n_fail++;
            $display("FAIL hold_ctrl: alu_ctrl=%b expected 0110", alu_ctrl);
        end
        step();
        n_checks++;
        if (result !== 32'd12 || zero !== 1'b0 || out_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL hold: result=%h zero=%b valid=%b expected 0000000c/0/0", result, zero, out_valid);
        end
        step();
        n_checks++;
        if (result !== 32'd12 || out_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL hold2: result=%h valid=%b expected 0000000c/0", result, out_valid);
        end
    endtask

    task automatic test_branch();
        @(negedge clk);
        branch = 1'b1; br_a = 32'h1234; br_b = 32'h1234; br_funct3 = 3'b000;
        #1;
        n_checks++;
        if (branch_taken !== 1'b1) begin
            n_fail++;
            $display("FAIL br_eq: branch_taken=%b expected 1", branch_taken);
        end
        br_b = 32'h1235;
        #1;
        n_checks++;
        if (branch_taken !== 1'b0) begin
            n_fail++;
            $display("FAIL br_ne: branch_taken=%b expected 0", branch_taken);
        end
        branch = 1'b0; br_b = 32'h1234;
        #1;
        n_checks++;
        if (branch_taken !== 1'b0) begin
            n_fail++;
            $display("FAIL br_off: branch_taken=%b expected 0", branch_taken);
        end
`ifdef EXU_BRANCH_EXT_EN
        branch = 1'b1; br_a = 32'hFFFF_FFFF; br_b = 32'h0; br_funct3 = 3'b100;
        #1;
        n_checks++;
        if (branch_taken !== 1'b1) begin
            n_fail++;
            $display("FAIL br_blt: branch_taken=%b expected 1", branch_taken);
        end
        br_funct3 = 3'b110;
        #1;
        n_checks++;
        if (branch_taken !== 1'b0) begin
            n_fail++;
            $display("FAIL br_bltu: branch_taken=%b expected 0", branch_taken);
        end
        br_funct3 = 3'b001;
        #1;
        n_checks++;
        if (branch_taken !== 1'b1) begin
            n_fail++;
            $display("FAIL br_bne: branch_taken=%b expected 1", branch_taken);
        end
        br_funct3 = 3'b111;
        #1;
        n_checks++;
        if (branch_taken !== 1'b1) begin
            n_fail++;
            $display("FAIL br_bgeu: branch_taken=%b expected 1", branch_taken);
        end
        br_funct3 = 3'b010;
        #1;
        n_checks++;
        if (branch_taken !== 1'b0) begin
            n_fail++;
            $display("FAIL br_f3_010: branch_taken=%b expected 0", branch_taken);
        end
`else
        // base build ignores br_funct3
        branch = 1'b1; br_a = 32'h55; br_b = 32'h55; br_funct3 = 3'b001;
        #1;
        n_checks++;
        if (branch_taken !== 1'b1) begin
            n_fail++;
            $display("FAIL br_f3_ignored: branch_taken=%b expected 1", branch_taken);
        end
`endif
        branch = 1'b0;
    endtask

    initial begin
        n_checks  = 0;
        n_fail    = 0;
        rst_n     = 1'b0;
        in_valid  = 1'b1;
        alu_op    = 2'b10;
        funct3    = 3'b000;
        funct7_b5 = 1'b0;
        op_a      = 32'd5;
        op_b      = 32'd7;
        branch    = 1'b0;
        br_a      = '0;
        br_b      = '0;
        br_funct3 = 3'b000;
        repeat (2) @(posedge clk);
        #1;
        test_reset();
        test_add_sub();
        test_logic();
        test_shift();
        test_compare();
        test_hold();
        test_branch();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/exec_alu_unit.md
Name: exec_alu_unit

Overview:
- Execute-stage arithmetic block for the 5-stage pipelined RISC core.
- It has three parts:
  - ALU-control decode from ALUOp/funct3/funct7[5] to a 4-bit operation code.
  - An N-bit ALU with a registered result.
  - A combinational branch resolver that drives the PC-select mux in ID.
- Sits between the ID/EX and EX/MEM pipeline registers. Operand forwarding muxes are outside this block.

Parameters:
- N, 32, datapath width. Must be a power of two, at least 8. Shift amount = low log2(N) bits of op_b.

Ports:
- clk  in  1  pipeline clock, rising edge
- rst_n  in  1  asynchronous active-low reset
- in_valid  in  1  operands/control valid this cycle
- alu_op  in  2  00 load/store add, 01 branch sub, 10 R-type, 11 I-type ALU
- funct3  in  3  instruction[14:12]
- funct7_b5  in  1  instruction[30]
- op_a  in  N  ALU operand A (forwarded rs1)
- op_b  in  N  ALU operand B (forwarded rs2 or immediate)
- branch  in  1  branch instruction in ID
- br_a  in  N  rs1 data for branch compare
- br_b  in  N  rs2 data for branch compare
- br_funct3  in  3  branch instruction funct3
- alu_ctrl  out  4  decoded operation, combinational
- result  out  N  registered ALU result
- zero  out  1  registered, result==0
- out_valid  out  1  registered copy of in_valid
- branch_taken  out  1  combinational branch decision

Behaviour:
- Decode (combinational):
  - alu_op=00 -> ADD (0010)
  - alu_op=01 -> SUB (0110)
- alu_op=10 (R-type), funct3 mapping:
  - 000 -> ADD, or SUB when funct7_b5=1
  - 111 AND 0000; 110 OR 0001; 100 XOR 0011; 001 SLL 0100
  - 101 -> SRL 0101, or SRA 1101 when funct7_b5=1
  - 010 SLT 0111; 011 SLTU 1000
- alu_op=11 (I-type): same funct3 mapping, except:
  - funct3=000 is always ADD; funct7_b5 is ignored.
  - funct7_b5 is honoured only for funct3=101.
- ALU operations:
  - ADD/SUB wrap modulo 2^N.
  - SLT is signed, SLTU unsigned; result is 1 or 0, zero-extended.
  - SRA sign-fills.
  - Any unlisted alu_ctrl value gives result 0.
- Registers: on the rising clk edge with in_valid=1, result and zero capture the ALU output and zero flag. With in_valid=0 they hold.
- out_valid <= in_valid every cycle. Latency is 1 cycle.
- Reset: rst_n low asynchronously forces result=0, zero=1, out_valid=0. This holds mid-operation too; the first capture happens on the first edge after deassertion.
- branch_taken is purely combinational with no register, because the PC mux needs it in the same cycle.
  - branch=0 -> branch_taken=0.
  - Base build: branch_taken = branch & (br_a==br_b). br_funct3 is ignored.
- alu_ctrl is combinational from the current inputs, independent of in_valid.

Optional Feature:
- Macro EXU_BRANCH_EXT_EN.
- Defined: branch_taken evaluates br_funct3 when branch=1:
  - 000 BEQ equal; 001 BNE not equal
  - 100 BLT signed <; 101 BGE signed >=
  - 110 BLTU unsigned <; 111 BGEU unsigned >=
  - 010/011 -> 0
- Undefined: equality-only behaviour as above.

Decomposition:
- Package exu_pkg holds:
  - 4-bit alu_ctrl localparams (ALU_AND .. ALU_SRA)
  - 2-bit ALUOp localparams
  - funct3 localparams for branches
- Natural sub-module: exu_alu_decode, the ALUOp/funct3/funct7 to alu_ctrl combinational decoder.
- The ALU datapath and branch compare stay in the top.

Test Plan:
- Reset: rst_n=0 with in_valid=1 and active operands -> result=0, zero=1, out_valid=0. Release rst_n -> first edge captures normally.
- R-type ADD/SUB, alu_op=10, funct3=000:
  - op_a=5, op_b=7, funct7_b5=0 -> alu_ctrl=0010; next cycle result=12, zero=0.
  - funct7_b5=1, op_a=7, op_b=7 -> alu_ctrl=0110; result=0, zero=1.
- Shifts, op_a=0x80000000, op_b=4, funct3=101:
  - funct7_b5=0 -> result=0x08000000.
  - funct7_b5=1 -> result=0xF8000000.
  - funct3=001 with op_b=33 -> shift by 1 -> result=0.
- Compare, op_a=0xFFFFFFFF, op_b=1:
  - SLT (010) -> result=1.
  - SLTU (011) -> result=0.
  - alu_op=11 with funct7_b5=1, funct3=000 -> ADD -> result=0.
- Hold/valid: in_valid=0 with new operands -> result unchanged and out_valid=0 next cycle.
- Branch resolution:
  - branch=1, br_a=br_b=0x1234 -> branch_taken=1 in the same cycle.
  - br_b=0x1235 -> 0.
  - branch=0 with equal operands -> 0.
  - With EXU_BRANCH_EXT_EN: br_funct3=100, br_a=-1, br_b=0 -> 1; br_funct3=110 -> 0.
